// File: rtl/frecventmetru_poarta.sv
// Gated frequency/period meter: counts rising edges of an asynchronous input over a
// window of GATE_CYCLES clocks, aligned to one input edge, and measures one period.
module frecventmetru_poarta #(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PER_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sig_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] freq_count,
    output logic [PER_W-1:0] period_cycles,
    output logic             period_valid,
    output logic             overflow,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_EDGE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam logic [PER_W-1:0] GATE_LAST = PER_W'(GATE_CYCLES);

    logic sync1, sync2, sync3;
    logic rise;

    state_t           state, state_n;
    logic [PER_W-1:0] gate_cnt, gate_n;
    logic [CNT_W-1:0] edge_cnt, edge_n;
    logic             edge_ovf, edge_ovf_n;
    logic [PER_W-1:0] period_lat, period_lat_n;
    logic             period_found, period_found_n;

    logic [CNT_W-1:0] freq_n;
    logic [PER_W-1:0] period_out_n;
    logic             valid_n, ovf_out_n, timeout_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            gate_cnt      <= '0;
            edge_cnt      <= '0;
            edge_ovf      <= 1'b0;
            period_lat    <= '0;
            period_found  <= 1'b0;
            freq_count    <= '0;
            period_cycles <= '0;
            period_valid  <= 1'b0;
            overflow      <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_n;
            gate_cnt      <= gate_n;
            edge_cnt      <= edge_n;
            edge_ovf      <= edge_ovf_n;
            period_lat    <= period_lat_n;
            period_found  <= period_found_n;
            freq_count    <= freq_n;
            period_cycles <= period_out_n;
            period_valid  <= valid_n;
            overflow      <= ovf_out_n;
            timeout       <= timeout_n;
        end
    end

    // Results are loaded on the edge entering ST_DONE so they appear together with done.
    always_comb begin
        state_n        = state;
        gate_n         = gate_cnt;
        edge_n         = edge_cnt;
        edge_ovf_n     = edge_ovf;
        period_lat_n   = period_lat;
        period_found_n = period_found;
        freq_n         = freq_count;
        period_out_n   = period_cycles;
        valid_n        = period_valid;
        ovf_out_n      = overflow;
        timeout_n      = timeout;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n        = ST_WAIT_EDGE;
                    gate_n         = '0;
                    edge_n         = '0;
                    edge_ovf_n     = 1'b0;
                    period_lat_n   = '0;
                    period_found_n = 1'b0;
                end
            end

            // gate_cnt is preset to 1 so that in ST_MEASURE it equals the window cycle number.
            ST_WAIT_EDGE: begin
                if (rise) begin
                    state_n        = ST_MEASURE;
                    gate_n         = PER_W'(1);
                    edge_n         = '0;
                    edge_ovf_n     = 1'b0;
                    period_lat_n   = '0;
                    period_found_n = 1'b0;
                end else if (gate_cnt == GATE_LAST - PER_W'(1)) begin
                    state_n      = ST_DONE;
                    freq_n       = '0;
                    period_out_n = '0;
                    valid_n      = 1'b0;
                    ovf_out_n    = 1'b0;
                    timeout_n    = 1'b1;
                end else begin
                    gate_n = gate_cnt + PER_W'(1);
                end
            end

            ST_MEASURE: begin
                if (rise) begin
                    if (edge_cnt == '1) begin
                        edge_ovf_n = 1'b1;
                    end else begin
                        edge_n = edge_cnt + CNT_W'(1);
                    end
                    if (!period_found) begin
                        period_lat_n   = gate_cnt;
                        period_found_n = 1'b1;
                    end
                end
                if (gate_cnt == GATE_LAST) begin
                    state_n      = ST_DONE;
                    freq_n       = edge_n;
                    period_out_n = period_found_n ? period_lat_n : '0;
                    valid_n      = period_found_n;
                    ovf_out_n    = edge_ovf_n;
                    timeout_n    = 1'b0;
                end else begin
                    gate_n = gate_cnt + PER_W'(1);
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule
